// File: rtl/uart_pkg.sv
// Shared definitions for the uart_echo block: FSM state encoding and the
// ASCII constants used by the optional lower-to-upper case mapping
// (enabled with the UART_ECHO_UPCASE_EN macro).
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_LC_A        = 8'h61;
  localparam logic [7:0] ASCII_LC_Z        = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

  // Map 'a'..'z' onto 'A'..'Z'; every other byte passes through untouched.
  function automatic logic [7:0] upcase(input logic [7:0] b);
    logic [7:0] r;
    if ((b >= ASCII_LC_A) && (b <= ASCII_LC_Z)) begin
      r = b - ASCII_CASE_OFFSET;
    end else begin
      r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_echo_fifo.sv
// Byte FIFO for uart_echo. A push into a full FIFO is accepted only when a
// pop happens on the same edge; pops from an empty FIFO are ignored.
module uart_echo_fifo #(
  parameter int depth = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [7:0]                   wdata,
  output logic [7:0]                   rdata,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  logic [7:0]    mem_q [depth];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count_q == CW'(depth));
  assign empty = (count_q == CW'(0));
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      wptr_d = (wptr_q == PW'(depth - 1)) ? PW'(0) : wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_ok) begin
      rptr_d = (rptr_q == PW'(depth - 1)) ? PW'(0) : rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= PW'(0);
      rptr_q  <= PW'(0);
      count_q <= CW'(0);
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_echo.sv
// uart_echo: buffers bytes from uart_rx and replays them to uart_tx with a
// req/cts handshake, tracking occupancy, a sticky overflow flag and a running
// sum of transmitted bytes. Define UART_ECHO_UPCASE_EN to upcase a..z at push.
module uart_echo
  import uart_pkg::*;
#(
  parameter int depth = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   i_data,
  input  logic                         i_valid,
  input  logic                         i_cts,
  output logic [7:0]                   o_data,
  output logic                         o_req,
  output logic [$clog2(depth+1)-1:0]   o_count,
  output logic                         o_overflow,
  output logic [31:0]                  o_sum
);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [7:0]  data_q, data_d;
  logic [31:0] sum_q, sum_d;
  logic        overflow_q, overflow_d;

  logic        xfer;
  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  fifo_wdata;
  logic [7:0]  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;

  uart_echo_fifo #(
    .depth (depth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .count (o_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, handshake and bookkeeping logic.
  always_comb begin
`ifdef UART_ECHO_UPCASE_EN
    fifo_wdata = upcase(i_data);
`else
    fifo_wdata = i_data;
`endif
    // req_q is only ever set in S_SEND with a non-empty FIFO, so cts is
    // effectively ignored while the FIFO is empty.
    xfer       = (state_q == S_SEND) && req_q && i_cts;
    fifo_push  = i_valid;
    fifo_pop   = xfer;
    overflow_d = overflow_q | (i_valid & fifo_full & ~xfer);
    if (xfer) begin
      sum_d = sum_q + {24'd0, data_q};
    end else begin
      sum_d = sum_q;
    end
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_SEND;
          req_d   = 1'b1;
          data_d  = fifo_head;
        end else begin
          req_d   = 1'b0;
        end
      end
      S_SEND: begin
        if (xfer) begin
          state_d = S_GAP;
          req_d   = 1'b0;
        end else begin
          req_d   = 1'b1;
        end
      end
      S_GAP: begin
        // One dead cycle so the same byte cannot be accepted twice.
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs; reset aborts any pending send.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      data_q     <= 8'd0;
      sum_q      <= 32'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      data_q     <= data_d;
      sum_q      <= sum_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_req      = req_q;
  assign o_data     = data_q;
  assign o_sum      = sum_q;
  assign o_overflow = overflow_q;

endmodule
